// File: rtl/down_timer_arbiter.sv
// down_timer_arbiter: round-robin arbiter that lends one shared down counter to one requester at a time.
module down_timer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_count,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic [WIDTH-1:0]         count_out,
   output logic [NUM_REQ-1:0]       done
);
   localparam int PW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
   state_t             r_state, w_state;
   logic [NUM_REQ-1:0] r_gnt, w_gnt, r_done, w_done;
   logic               r_busy, w_busy;
   logic [WIDTH-1:0]   r_cnt, w_cnt;
   logic [PW-1:0]      r_ptr, w_ptr, r_own, w_own, w_win, w_own_inc;
   logic               w_found;
   logic [WIDTH-1:0]   w_load [NUM_REQ];
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_load
      assign w_load[g] = req_count[g*WIDTH +: WIDTH];
   end
   // first active request at or after the pointer, wrapping
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && req[PW'((int'(r_ptr) + k) % NUM_REQ)]) begin
            w_found = 1'b1;
            w_win   = PW'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end
   assign w_own_inc = (r_own == PW'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;
   // withdrawal is tested before terminal count so it wins a same-cycle collision
   always_comb begin
      w_state = r_state;
      w_gnt   = r_gnt;
      w_busy  = r_busy;
      w_cnt   = r_cnt;
      w_done  = '0;
      w_ptr   = r_ptr;
      w_own   = r_own;
      case (r_state)
         IDLE: if (w_found) begin
            w_state = COUNT;
            w_gnt   = NUM_REQ'(1) << w_win;
            w_busy  = 1'b1;
            w_cnt   = w_load[w_win];
            w_own   = w_win;
         end
         COUNT: if (!req[r_own]) begin
            w_state = IDLE;
            w_gnt   = '0;
            w_busy  = 1'b0;
            w_ptr   = w_own_inc;
         end else if (r_cnt != '0) begin
            w_cnt = r_cnt - 1'b1;
         end else begin
            w_state = DONE;
            w_done  = r_gnt;
         end
         default: begin
            w_state = IDLE;
            w_gnt   = '0;
            w_busy  = 1'b0;
            w_ptr   = w_own_inc;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_done  <= '0;
         r_ptr   <= '0;
         r_own   <= '0;
      end else begin
         r_state <= w_state;
         r_gnt   <= w_gnt;
         r_busy  <= w_busy;
         r_cnt   <= w_cnt;
         r_done  <= w_done;
         r_ptr   <= w_ptr;
         r_own   <= w_own;
      end
   end
   assign gnt       = r_gnt;
   assign busy      = r_busy;
   assign count_out = r_cnt;
   assign done      = r_done;
endmodule

// File: tb/tb_down_timer_arbiter.sv
// tb_down_timer_arbiter: scoreboard bench; expected per-cycle outputs are queued with each stimulus and compared after each edge.
module tb_down_timer_arbiter;
   logic        clk;
   logic        rstn;
   logic [3:0]  req;
   logic [31:0] req_count;
   logic [3:0]  gnt;
   logic        busy;
   logic [7:0]  count_out;
   logic [3:0]  done;
   int          n_vec;
   int          n_err;
   string       scen;
   typedef struct {
      logic [3:0] g;
      logic       b;
      logic [7:0] c;
      logic [3:0] d;
   } exp_t;
   exp_t q[$];
   down_timer_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_count(req_count),
      .gnt(gnt), .busy(busy), .count_out(count_out), .done(done)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got %0h expected %0h", scen, tag, got, exp);
      end
   endtask
   task automatic chk_zero();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(count_out), 0);
      chk("rst_done", 32'(done), 0);
   endtask
   task automatic push(input logic [3:0] g, input logic b, input logic [7:0] c, input logic [3:0] d);
      exp_t e;
      e.g = g;
      e.b = b;
      e.c = c;
      e.d = d;
      q.push_back(e);
   endtask
   // grant with load l: l+1 COUNT cycles counting l..0, then one DONE cycle
   task automatic push_xact(input int idx, input int l);
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      for (int v = l; v >= 0; v--) push(oh, 1'b1, 8'(v), 4'b0000);
      push(oh, 1'b1, 8'd0, oh);
   endtask
   task automatic run(input int n);
      exp_t e;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = q.pop_front();
         chk("gnt", 32'(gnt), 32'(e.g));
         chk("busy", 32'(busy), 32'(e.b));
         chk("cnt", 32'(count_out), 32'(e.c));
         chk("done", 32'(done), 32'(e.d));
      end
   endtask
   task automatic run_all();
      run(q.size());
   endtask
   initial begin
      n_vec = 0;
      n_err = 0;
      scen = "reset";
      rstn = 1'b0;
      req = '0;
      req_count = '0;
      #2;
      chk_zero();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      scen = "single";
      req = 4'b0001;
      req_count[7:0] = 8'd3;
      push_xact(0, 3);
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      scen = "zero_load";
      req = 4'b0100;
      req_count[23:16] = 8'd0;
      push_xact(2, 0);
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      scen = "abort";
      req = 4'b0010;
      req_count[15:8] = 8'd10;
      for (int v = 10; v >= 6; v--) push(4'b0010, 1'b1, 8'(v), 4'b0000);
      run(1);
      req_count[15:8] = 8'hAA;
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd6, 4'b0000);
      run_all();
      scen = "after_abort";
      req = 4'b0110;
      req_count[15:8] = 8'd5;
      req_count[23:16] = 8'd1;
      push_xact(2, 1);
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      scen = "collision";
      req = 4'b1000;
      req_count[31:24] = 8'd2;
      for (int v = 2; v >= 0; v--) push(4'b1000, 1'b1, 8'(v), 4'b0000);
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      scen = "mid_reset";
      req = 4'b1000;
      req_count[31:24] = 8'd20;
      for (int v = 20; v >= 12; v--) push(4'b1000, 1'b1, 8'(v), 4'b0000);
      run_all();
      #2;
      rstn = 1'b0;
      #1;
      chk_zero();
      @(posedge clk);
      #1;
      chk_zero();
      rstn = 1'b1;
      req = 4'b1001;
      req_count[7:0] = 8'd2;
      req_count[31:24] = 8'd5;
      push_xact(0, 2);
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      scen = "round_robin";
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk_zero();
      rstn = 1'b1;
      req = 4'b1111;
      req_count = {8'd1, 8'd1, 8'd1, 8'd1};
      for (int r = 0; r < 5; r++) begin
         push_xact(r % 4, 1);
         if (r < 4) push(4'b0000, 1'b0, 8'd0, 4'b0000);
      end
      run_all();
      req = '0;
      push(4'b0000, 1'b0, 8'd0, 4'b0000);
      run_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/down_timer_arbiter.md
DOWN_TIMER_ARBITER -- requirements
Module: down_timer_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one down counter (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, meaning down-counter width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester request; held high until its done pulse.
REQ-006 SHALL have port req_count  input  NUM_REQ*WIDTH  load values, requester i in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot current owner of the counter, all-zero when idle.
REQ-008 SHALL have port busy  output  1  high while any grant is held.
REQ-009 SHALL have port count_out  output  WIDTH  current down-counter value.
REQ-010 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owner.

Function
REQ-011 SHALL implement FSM states IDLE, COUNT, DONE; all outputs registered.
REQ-012 IDLE: if req nonzero, SHALL select winner by round-robin starting at index ptr, wrapping NUM_REQ-1 -> 0; at that edge gnt <= onehot(winner), count_out <= req_count[winner], busy <= 1, state <= COUNT.
REQ-013 IDLE with req all-zero SHALL hold gnt=0, busy=0, done=0, count_out unchanged.
REQ-014 COUNT with req[owner]=1 and count_out!=0 SHALL decrement count_out by 1 per cycle; no wrap-around below 0.
REQ-015 COUNT with req[owner]=1 and count_out==0 SHALL go to DONE, asserting done[owner] for exactly that DONE cycle; gnt held.
REQ-016 DONE SHALL return to IDLE next edge: gnt <= 0, busy <= 0, done <= 0, ptr <= (owner+1) mod NUM_REQ.
REQ-017 Latency: load value L SHALL give gnt high L+2 cycles (L+1 in COUNT, 1 in DONE); L=0 gives done one cycle after COUNT entry.
REQ-018 COUNT with req[owner]=0 (withdrawal) SHALL abort: state <= IDLE, gnt <= 0, busy <= 0, no done pulse, ptr <= (owner+1) mod NUM_REQ, count_out holds last value.
REQ-019 Withdrawal has priority over terminal count in the same cycle (abort, no done).
REQ-020 req_count changes after grant SHALL be ignored; value captured at grant edge only.
REQ-021 Requests from non-owners during COUNT/DONE SHALL be ignored until IDLE; no preemption.
REQ-022 A requester whose req stays high through DONE SHALL be eligible again in IDLE, but behind others per pointer.
REQ-023 At most one gnt bit and at most one done bit SHALL be high in any cycle; done bit only equals current gnt bit.
REQ-024 Minimum one IDLE cycle SHALL occur between consecutive grants.

Reset
REQ-025 rstn low SHALL immediately force state IDLE, gnt=0, busy=0, done=0, count_out=0, ptr=0, regardless of clk.
REQ-026 Reset mid-COUNT or mid-DONE SHALL discard the operation with no done pulse; first arbitration after release starts from index 0.
REQ-027 After rstn deasserts, first grant SHALL occur on the first rising edge with req nonzero.

Verification
REQ-028 Single request: req=0001, count0=3 -> gnt=0001 next edge, count_out 3,2,1,0, then done=0001 one cycle, gnt=0 after; gnt high 5 cycles.
REQ-029 Round-robin: req=1111 held, all counts=1 -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-030 Zero load: req=0100, count2=0 -> COUNT with count_out=0 one cycle, then done=0100, then IDLE.
REQ-031 Abort: req=0010, count1=10, drop req1 when count_out=6 -> gnt=0 next edge, no done, count_out stays 6, next grant searches from index 2.
REQ-032 Reset mid-count: req=1000, count3=20, rstn low at count_out=12 -> all outputs 0 asynchronously; after release with req=1001, grant goes to index 0.
REQ-033 Abort/terminal collision: drop req on the cycle count_out==0 -> no done pulse, IDLE next.
